// File: rtl/i2c_txn_arbiter.sv
// Round-robin arbiter and single-register transaction sequencer sharing one I2C master.
// Define I2C_ARB_TIMEOUT_EN to add the m_done watchdog that aborts a stalled transfer with err.
module i2c_txn_arbiter #(
  parameter int unsigned N_REQ       = 2,
  parameter int unsigned TIMEOUT_CYC = 4096
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ-1:0]   req_rw,
  input  logic [7*N_REQ-1:0] req_addr,
  input  logic [8*N_REQ-1:0] req_reg,
  input  logic [8*N_REQ-1:0] req_wdata,
  output logic [N_REQ-1:0]   gnt,
  output logic [N_REQ-1:0]   done,
  output logic [N_REQ-1:0]   err,
  output logic [7:0]         rdata,
  output logic               m_enable,
  output logic               m_read_write,
  output logic [6:0]         m_address,
  output logic [7:0]         m_address_of_reg,
  output logic [7:0]         m_data_in,
  input  logic               m_busy,
  input  logic               m_done,
  input  logic               m_nack,
  input  logic [7:0]         m_rdata
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StGrant    = 3'd1;
  localparam logic [2:0] StLaunch   = 3'd2;
  localparam logic [2:0] StWaitBusy = 3'd3;
  localparam logic [2:0] StWaitDone = 3'd4;
  localparam logic [2:0] StResp     = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [IdxW-1:0] idx_q, idx_d;
  logic [IdxW-1:0] win_idx, cand;
  logic            win_found;
  logic [N_REQ-1:0] gnt_q, gnt_d;
  logic [N_REQ-1:0] done_q, done_d;
  logic [N_REQ-1:0] err_q, err_d;
  logic [7:0]      rdata_q, rdata_d;
  logic            en_q, en_d;
  logic            rw_q, rw_d;
  logic [6:0]      addr_q, addr_d;
  logic [7:0]      reg_q, reg_d;
  logic [7:0]      wdata_q, wdata_d;
  logic            timeout;

`ifdef I2C_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Fires on the pre-increment value so err lands exactly TIMEOUT_CYC cycles after LAUNCH.
  assign timeout = (cnt_q == CntW'(TIMEOUT_CYC - 2));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StLaunch) begin
      cnt_d = '0;
    end else if (state_q == StWaitBusy || state_q == StWaitDone) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYC;
  assign timeout = 1'b0;
`endif

  // First pending requester at or above the pointer, wrapping around.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + 32'(k)) % N_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    en_d    = 1'b0;
    rdata_d = rdata_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    reg_d   = reg_q;
    wdata_d = wdata_q;

    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          idx_d   = win_idx;
          gnt_d   = N_REQ'(1) << win_idx;
          rw_d    = req_rw[win_idx];
          addr_d  = req_addr[7*win_idx +: 7];
          reg_d   = req_reg[8*win_idx +: 8];
          wdata_d = req_wdata[8*win_idx +: 8];
          state_d = StGrant;
        end
      end
      StGrant: begin
        en_d    = 1'b1;
        state_d = StLaunch;
      end
      StLaunch: begin
        state_d = StWaitBusy;
      end
      StWaitBusy, StWaitDone: begin
        // A fast master may finish before busy is ever seen.
        if (m_done) begin
          state_d = StResp;
          if (m_nack) begin
            err_d = gnt_q;
          end else begin
            done_d = gnt_q;
            if (rw_q) begin
              rdata_d = m_rdata;
            end
          end
        end else if (timeout) begin
          state_d = StResp;
          err_d   = gnt_q;
        end else if (state_q == StWaitBusy && m_busy) begin
          state_d = StWaitDone;
        end
      end
      StResp: begin
        gnt_d   = '0;
        ptr_d   = (32'(idx_q) == N_REQ - 1) ? '0 : idx_q + 1'b1;
        state_d = StIdle;
      end
      default: begin
        gnt_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      idx_q   <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      rdata_q <= '0;
      en_q    <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
      en_q    <= en_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
    end
  end

  assign gnt              = gnt_q;
  assign done             = done_q;
  assign err              = err_q;
  assign rdata            = rdata_q;
  assign m_enable         = en_q;
  assign m_read_write     = rw_q;
  assign m_address        = addr_q;
  assign m_address_of_reg = reg_q;
  assign m_data_in        = wdata_q;

endmodule

// File: tb/tb_i2c_txn_arbiter.sv
// Self-checking bench for i2c_txn_arbiter: directed plan steps plus randomized transactions
// against a transaction-level round-robin model; timeout cases need I2C_ARB_TIMEOUT_EN.
module tb_i2c_txn_arbiter;

  localparam int N  = 2;
  localparam int TO = 16;
`ifdef I2C_ARB_TIMEOUT_EN
  localparam bit ToEn  = 1'b1;
  localparam int WrDly = 12;
`else
  localparam bit ToEn  = 1'b0;
  localparam int WrDly = 20;
`endif

  logic           clk = 1'b0;
  logic           reset;
  logic [N-1:0]   req, req_rw, gnt, done, err;
  logic [7*N-1:0] req_addr;
  logic [8*N-1:0] req_reg, req_wdata;
  logic [7:0]     rdata, m_address_of_reg, m_data_in, m_rdata;
  logic [6:0]     m_address;
  logic           m_enable, m_read_write, m_busy, m_done, m_nack;

  always #5 clk = ~clk;

  i2c_txn_arbiter #(.N_REQ(N), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset(reset), .req(req), .req_rw(req_rw), .req_addr(req_addr),
    .req_reg(req_reg), .req_wdata(req_wdata), .gnt(gnt), .done(done), .err(err),
    .rdata(rdata), .m_enable(m_enable), .m_read_write(m_read_write), .m_address(m_address),
    .m_address_of_reg(m_address_of_reg), .m_data_in(m_data_in), .m_busy(m_busy),
    .m_done(m_done), .m_nack(m_nack), .m_rdata(m_rdata)
  );

  // Master response profile, picked up at each m_enable.
  int unsigned cfg_busy_dly = 2, cfg_done_dly = 10;
  bit          cfg_nack = 1'b0, cfg_hang = 1'b0;
  logic [7:0]  cfg_rdata = 8'h00;

  initial begin : master
    int unsigned t, bd, dd;
    bit act, nk, hg;
    logic [7:0] rd;
    act = 0; t = 0; bd = 0; dd = 0; nk = 0; hg = 0; rd = 0;
    m_busy = 0; m_done = 0; m_nack = 0; m_rdata = 0;
    forever begin
      @(negedge clk);
      if (!reset) act = 0;
      else if (m_enable) begin
        act = 1; t = 0; bd = cfg_busy_dly; dd = cfg_done_dly;
        nk = cfg_nack; hg = cfg_hang; rd = cfg_rdata;
      end else if (act) t++;
      m_busy  = act && t >= bd && (hg || t < dd);
      m_done  = act && !hg && t == dd;
      m_nack  = act && nk;
      m_rdata = m_done ? rd : 8'hEE;
      if (m_done) act = 0;
    end
  end

  int n_checks = 0, n_pass = 0;
  int mdl_ptr = 0;
  logic [7:0] mdl_rdata = 8'h00;
  logic [6:0] f_addr[N];
  logic [7:0] f_reg[N], f_wd[N];
  logic       f_rw[N];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  task automatic set_req(input int i, input logic [6:0] a, input logic [7:0] rg,
                         input logic [7:0] wd, input logic rw);
    req_addr[7*i +: 7] = a;  f_addr[i] = a;
    req_reg[8*i +: 8]  = rg; f_reg[i]  = rg;
    req_wdata[8*i +: 8] = wd; f_wd[i]  = wd;
    req_rw[i] = rw;          f_rw[i]   = rw;
  endtask

  function automatic int rr_pick(input logic [N-1:0] r);
    for (int k = 0; k < N; k++) if (r[(mdl_ptr + k) % N]) return (mdl_ptr + k) % N;
    return 0;
  endfunction

  // One whole transaction: grant, launch, response, release, checked against the model.
  task automatic serve(input string tag, input bit perturb, output int glat, output int win);
    int n, dly;
    bit ok, to, nk, rw;
    logic [23:0] ef;
    logic [7:0] crd;
    win = rr_pick(req);
    rw  = f_rw[win];
    ef  = {f_rw[win], f_addr[win], f_reg[win], f_wd[win]};
    dly = int'(cfg_done_dly); nk = cfg_nack; crd = cfg_rdata;
    to  = cfg_hang || (ToEn && cfg_done_dly >= TO);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 16);
    glat = n;
    chk({tag, "_gnt"}, 32'(gnt), 32'(1) << win);
    chk({tag, "_en_grant"}, 32'(m_enable), 32'd0);
    chk({tag, "_fields"}, 32'({m_read_write, m_address, m_address_of_reg, m_data_in}), 32'(ef));
    if (perturb) begin
      set_req(win, ~ef[22:16], ~ef[15:8], ~ef[7:0], ~ef[23]);
      req[win] = 1'b0;
    end
    @(negedge clk);
    chk({tag, "_en_launch"}, 32'(m_enable), 32'd1);
    chk({tag, "_fields_held"}, 32'({m_read_write, m_address, m_address_of_reg, m_data_in}),
        32'(ef));
    n = 0; ok = 1;
    do begin
      @(negedge clk); n++;
      if (gnt !== (N'(1) << win)) ok = 0;
    end while (done == '0 && err == '0 && n < 64);
    chk({tag, "_resp_latency"}, 32'(n), to ? 32'(TO) : 32'(dly + 1));
    chk({tag, "_gnt_held"}, 32'(ok), 32'd1);
    chk({tag, "_done"}, 32'(done), (to || nk) ? 32'd0 : 32'(1) << win);
    chk({tag, "_err"}, 32'(err), (to || nk) ? 32'(1) << win : 32'd0);
    if (!to && !nk && rw) mdl_rdata = crd;
    chk({tag, "_rdata"}, 32'(rdata), 32'(mdl_rdata));
    mdl_ptr = (win + 1) % N;
    @(negedge clk);
    chk({tag, "_release"}, 32'({gnt, done, err, m_enable}), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int lat, w, n;
    bit ok;
    reset = 1'b0; req = '0; req_rw = '0; req_addr = '0; req_reg = '0; req_wdata = '0;
    for (int i = 0; i < N; i++) set_req(i, 7'h00, 8'h00, 8'h00, 1'b0);
    repeat (3) @(negedge clk);
    chk("rst_ctrl", 32'({gnt, done, err, m_enable, m_read_write}), 32'd0);
    chk("rst_data", 32'({m_address, m_address_of_reg, m_data_in}), 32'd0);
    chk("rst_rdata", 32'(rdata), 32'd0);
    reset = 1'b1;

    // Single write from requester 0.
    set_req(0, 7'h50, 8'h10, 8'hA5, 1'b0);
    cfg_busy_dly = 2; cfg_done_dly = WrDly; cfg_nack = 0; cfg_hang = 0; cfg_rdata = 8'h99;
    @(negedge clk);
    req = 2'b01;
    serve("wr", 1'b0, lat, w);
    chk("wr_capture_latency", 32'(lat), 32'd1);
    req = '0;

    // Read by requester 1; rdata must persist afterwards.
    set_req(1, 7'h21, 8'h05, 8'h00, 1'b1);
    cfg_done_dly = 8; cfg_rdata = 8'h3C;
    req = 2'b10;
    serve("rd", 1'b0, lat, w);
    req = '0;
    repeat (3) @(negedge clk);
    chk("rd_hold", 32'(rdata), 32'h3C);

    // Contention with both held: expect 0,1,0,1.
    set_req(0, 7'h11, 8'h22, 8'h33, 1'b0);
    set_req(1, 7'h44, 8'h55, 8'h66, 1'b1);
    cfg_done_dly = 4; cfg_rdata = 8'h7E;
    req = 2'b11;
    for (int i = 0; i < 4; i++) serve("cont", 1'b0, lat, w);
    req = '0;

    // NACK on requester 0.
    set_req(0, 7'h50, 8'h01, 8'h02, 1'b1);
    cfg_nack = 1; cfg_done_dly = 6; cfg_rdata = 8'hC3;
    req = 2'b01;
    serve("nack", 1'b0, lat, w);
    req = '0;
    cfg_nack = 0;

    // Reset during WAIT_DONE: everything clears, pointer returns to 0.
    cfg_done_dly = 20;
    req = 2'b11;
    w = rr_pick(req);
    n = 0;
    do begin @(negedge clk); n++; end while (gnt == '0 && n < 16);
    chk("midrst_gnt", 32'(gnt), 32'(1) << w);
    ok = 1;
    repeat (6) begin @(negedge clk); if (done != '0 || err != '0) ok = 0; end
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    chk("midrst_ctrl", 32'({gnt, done, err, m_enable, m_read_write}), 32'd0);
    chk("midrst_data", 32'({m_address, m_address_of_reg, m_data_in, rdata}), 32'd0);
    chk("midrst_no_resp", 32'(ok), 32'd1);
    mdl_ptr = 0; mdl_rdata = 8'h00;
    cfg_done_dly = 5;
    serve("midrst_next", 1'b0, lat, w);
    req = '0;

`ifdef I2C_ARB_TIMEOUT_EN
    // Hung master times out; the other requester is then served; done at the last legal cycle.
    cfg_hang = 1;
    req = 2'b11;
    serve("to_hang", 1'b0, lat, w);
    cfg_hang = 0; cfg_done_dly = TO - 1; cfg_rdata = 8'h5A;
    serve("to_edge_ok", 1'b0, lat, w);
    cfg_done_dly = TO;
    serve("to_edge_late", 1'b0, lat, w);
    req = '0;
`endif

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      for (int r = 0; r < N; r++)
        set_req(r, 7'($urandom), 8'($urandom), 8'($urandom), 1'($urandom));
      cfg_busy_dly = $urandom_range(0, 3);
      cfg_done_dly = $urandom_range(1, 12);
      cfg_nack     = ($urandom_range(0, 3) == 0);
      cfg_hang     = ToEn && ($urandom_range(0, 5) == 0);
      cfg_rdata    = 8'($urandom);
      req = N'($urandom_range(1, (1 << N) - 1));
      serve("rnd", 1'($urandom), lat, w);
      if ($urandom_range(0, 1) == 1) begin
        req = '0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    req = '0;
    cfg_hang = 0;
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
